// File: rtl/led_ctrl_pkg.sv
// Shared LED mode codes, lamp-test state encodings and the per-LED
// priority helper for the baseboard LED controller.
package led_ctrl_pkg;

  typedef enum logic [3:0] {
    LED_OFF        = 4'h0,
    LED_ON         = 4'h1,
    BLK_1HZ        = 4'h2,
    BLK_2HZ        = 4'h3,
    BLK_4HZ        = 4'h4,
    BLK_4HZ_500MS  = 4'h5,
    BLK_4HZ_3500MS = 4'h6,
    BLK_07S        = 4'h7
  } led_mode_e;

  typedef enum logic [1:0] {
    LT_IDLE  = 2'd0,
    LT_WALK  = 2'd1,
    LT_ALLON = 2'd2
  } lt_state_e;

  localparam int NUM_LEDS = 16;
  localparam int NUM_REGS = 8;
  localparam int PH_LAST  = 159;
  localparam int C07_LAST = 27;

  localparam logic [7:0] SH_RESET = {LED_OFF, LED_OFF};

  // Lamp test beats fault, fault beats the host-written shadow nibble.
  function automatic logic [3:0] merge_nibble(input logic       lamp_active,
                                              input logic       lamp_on,
                                              input logic       fault,
                                              input logic [3:0] shadow);
    if (lamp_active) return lamp_on ? LED_ON : LED_OFF;
    if (fault)       return BLK_4HZ;
    return shadow;
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Host register bus of the LED controller: write strobe, address, data
// and the registered shadow read-back.
interface led_ctrl_if;

  logic       HOST_WR;
  logic [2:0] HOST_ADDR;
  logic [7:0] HOST_WDATA;
  logic [7:0] HOST_RDATA;

  modport master (output HOST_WR, HOST_ADDR, HOST_WDATA, input HOST_RDATA);
  modport slave  (input HOST_WR, HOST_ADDR, HOST_WDATA, output HOST_RDATA);

endinterface

// File: rtl/led_timebase.sv
// Base tick, 4 s phase frame and the six registered blink phase clocks.
module led_timebase
  import led_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 625_000
) (
  input  logic SYSCLK,
  input  logic RESET,
  output logic tick,
  output logic clk_1hz,
  output logic clk_2hz,
  output logic clk_4hz,
  output logic clk_4hz_500ms,
  output logic clk_4hz_3500ms,
  output logic clk_07s
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    ph_q, ph_d;
  logic [4:0]    c07_q, c07_d;
  logic [5:0]    phase_q, phase_d;
  logic [7:0]    mod10, mod20, mod40;
  logic          burst_4hz;

  assign tick = (tcnt_q == TW'(TICK_CYCLES - 1));

  // Phase clocks are derived from the post-tick phase so they move together with ph.
  always_comb begin
    tcnt_d    = tick ? '0 : tcnt_q + TW'(1);
    ph_d      = ph_q;
    c07_d     = c07_q;
    phase_d   = phase_q;
    mod10     = '0;
    mod20     = '0;
    mod40     = '0;
    burst_4hz = 1'b0;
    if (tick) begin
      ph_d      = (ph_q == 8'(PH_LAST)) ? '0 : ph_q + 8'd1;
      c07_d     = (c07_q == 5'(C07_LAST)) ? '0 : c07_q + 5'd1;
      mod10     = ph_d % 8'd10;
      mod20     = ph_d % 8'd20;
      mod40     = ph_d % 8'd40;
      burst_4hz = (mod10 < 8'd5);
      phase_d   = {mod40 < 8'd20,
                   mod20 < 8'd10,
                   burst_4hz,
                   burst_4hz & (mod40 < 8'd20),
                   burst_4hz & (ph_d < 8'd20),
                   (c07_q == 5'(C07_LAST)) ? ~phase_q[0] : phase_q[0]};
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      tcnt_q  <= '0;
      ph_q    <= '0;
      c07_q   <= '0;
      phase_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      ph_q    <= ph_d;
      c07_q   <= c07_d;
      phase_q <= phase_d;
    end
  end

  assign {clk_1hz, clk_2hz, clk_4hz, clk_4hz_500ms, clk_4hz_3500ms, clk_07s} = phase_q;

endmodule

// File: rtl/led_ctrl.sv
// LED controller top: host shadow registers, fault/lamp-test priority merge
// and the lamp-test sequencer, driving the LED multiplexer directly.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 625_000,
  parameter int STEP_TICKS  = 8,
  parameter int HOLD_TICKS  = 40
) (
  input  logic         SYSCLK,
  input  logic         RESET,
  led_ctrl_if.slave    host,
  input  logic [15:0]  FAULT,
  input  logic         LAMP_TEST,
  output logic         LAMP_BUSY,
  output logic [7:0]   LED_REG0,
  output logic [7:0]   LED_REG1,
  output logic [7:0]   LED_REG2,
  output logic [7:0]   LED_REG3,
  output logic [7:0]   LED_REG4,
  output logic [7:0]   LED_REG5,
  output logic [7:0]   LED_REG6,
  output logic [7:0]   LED_REG7,
  output logic         CLK_1HZ,
  output logic         CLK_2HZ,
  output logic         CLK_4HZ,
  output logic         CLK_4HZ_500MS,
  output logic         CLK_4HZ_3500MS,
  output logic         CLK_07S
);

  localparam int MAXT = (HOLD_TICKS > STEP_TICKS) ? HOLD_TICKS : STEP_TICKS;
  localparam int SW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  logic            tick;
  logic [7:0]      sh_q [NUM_REGS];
  logic [7:0]      sh_d [NUM_REGS];
  logic [63:0]     sh_flat;
  logic [7:0]      rdata_q, rdata_d;
  logic            lt_prev_q, lt_prev_d, lt_rise_q, lt_rise_d;
  lt_state_e       state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [SW-1:0]   step_q, step_d;
  logic            busy_q, busy_d;
  logic [63:0]     led_q, led_d;

  led_timebase #(.TICK_CYCLES(TICK_CYCLES)) u_timebase (
    .SYSCLK        (SYSCLK),
    .RESET         (RESET),
    .tick          (tick),
    .clk_1hz       (CLK_1HZ),
    .clk_2hz       (CLK_2HZ),
    .clk_4hz       (CLK_4HZ),
    .clk_4hz_500ms (CLK_4HZ_500MS),
    .clk_4hz_3500ms(CLK_4HZ_3500MS),
    .clk_07s       (CLK_07S)
  );

  always_comb begin
    sh_d = sh_q;
    if (host.HOST_WR) sh_d[host.HOST_ADDR] = host.HOST_WDATA;
    rdata_d   = sh_q[host.HOST_ADDR];
    lt_prev_d = LAMP_TEST;
    lt_rise_d = LAMP_TEST & ~lt_prev_q;
  end

  // Edges arriving while busy are dropped; step counting only advances on ticks.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    unique case (state_q)
      LT_IDLE: begin
        if (lt_rise_q) begin
          state_d = LT_WALK;
          idx_d   = '0;
          step_d  = '0;
        end
      end
      LT_WALK: begin
        if (tick) begin
          if (step_q == SW'(STEP_TICKS - 1)) begin
            step_d = '0;
            if (idx_q == 4'd15) state_d = LT_ALLON;
            else                idx_d   = idx_q + 4'd1;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      LT_ALLON: begin
        if (tick) begin
          if (step_q == SW'(HOLD_TICKS - 1)) begin
            state_d = LT_IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: state_d = LT_IDLE;
    endcase
    busy_d = (state_d != LT_IDLE);
  end

  // The merge looks at the next lamp state so the pattern lands with LAMP_BUSY.
  always_comb begin
    sh_flat = '0;
    led_d   = '0;
    for (int r = 0; r < NUM_REGS; r++) sh_flat[r*8 +: 8] = sh_q[r];
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i*4 +: 4] = merge_nibble(state_d != LT_IDLE,
                                     (state_d == LT_ALLON) || (idx_d == 4'(i)),
                                     FAULT[i], sh_flat[i*4 +: 4]);
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      sh_q      <= '{default: SH_RESET};
      rdata_q   <= '0;
      lt_prev_q <= 1'b0;
      lt_rise_q <= 1'b0;
      state_q   <= LT_IDLE;
      idx_q     <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      led_q     <= {NUM_REGS{SH_RESET}};
    end else begin
      sh_q      <= sh_d;
      rdata_q   <= rdata_d;
      lt_prev_q <= lt_prev_d;
      lt_rise_q <= lt_rise_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign host.HOST_RDATA = rdata_q;
  assign LAMP_BUSY       = busy_q;
  assign LED_REG0        = led_q[ 7: 0];
  assign LED_REG1        = led_q[15: 8];
  assign LED_REG2        = led_q[23:16];
  assign LED_REG3        = led_q[31:24];
  assign LED_REG4        = led_q[39:32];
  assign LED_REG5        = led_q[47:40];
  assign LED_REG6        = led_q[55:48];
  assign LED_REG7        = led_q[63:56];

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: a cycle-level reference model predicts every
// registered output from tick counts and a flat shadow image.
module tb_led_ctrl;
  import led_ctrl_pkg::*;

  localparam int TC   = 4;
  localparam int STEP = 8;
  localparam int HOLD = 40;
  localparam int WALK_TICKS = 16 * STEP;

  logic        SYSCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic [15:0] FAULT  = '0;
  logic        LAMP_TEST = 1'b0;
  logic        LAMP_BUSY;
  logic [7:0]  LED_REG0, LED_REG1, LED_REG2, LED_REG3;
  logic [7:0]  LED_REG4, LED_REG5, LED_REG6, LED_REG7;
  logic        CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS, CLK_4HZ_3500MS, CLK_07S;

  led_ctrl_if host_bus();

  led_ctrl #(.TICK_CYCLES(TC), .STEP_TICKS(STEP), .HOLD_TICKS(HOLD)) dut (
    .SYSCLK        (SYSCLK),
    .RESET         (RESET),
    .host          (host_bus),
    .FAULT         (FAULT),
    .LAMP_TEST     (LAMP_TEST),
    .LAMP_BUSY     (LAMP_BUSY),
    .LED_REG0      (LED_REG0),
    .LED_REG1      (LED_REG1),
    .LED_REG2      (LED_REG2),
    .LED_REG3      (LED_REG3),
    .LED_REG4      (LED_REG4),
    .LED_REG5      (LED_REG5),
    .LED_REG6      (LED_REG6),
    .LED_REG7      (LED_REG7),
    .CLK_1HZ       (CLK_1HZ),
    .CLK_2HZ       (CLK_2HZ),
    .CLK_4HZ       (CLK_4HZ),
    .CLK_4HZ_500MS (CLK_4HZ_500MS),
    .CLK_4HZ_3500MS(CLK_4HZ_3500MS),
    .CLK_07S       (CLK_07S)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic [63:0] led;
    logic [7:0]  rdata;
    logic        busy;
    logic [5:0]  clk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Blink phases as a function of the number of base ticks since reset.
  function automatic logic [5:0] model_clocks(input int ticks);
    int   p;
    logic b4;
    if (ticks == 0) return 6'b0;
    p  = ticks % 160;
    b4 = (p % 10) < 5;
    return {(p % 40) < 20, (p % 20) < 10, b4, b4 && ((p % 40) < 20), b4 && (p < 20),
            ((ticks / 28) % 2) == 1};
  endfunction

  // Reference model: lamp progress is tracked as ticks elapsed since entry.
  always @(posedge SYSCLK) begin : model_proc
    static int          k_m = 0;
    static int          t_m = 0;
    static logic        busy_m = 1'b0;
    static logic        rise_m = 1'b0;
    static logic        lt_last_m = 1'b0;
    static logic [63:0] sh_m = '0;
    exp_t        e;
    logic        tick_prev;
    logic [3:0]  nib;
    if (RESET) begin
      k_m = 0; t_m = 0; busy_m = 1'b0; rise_m = 1'b0; lt_last_m = 1'b0; sh_m = '0;
    end else begin
      tick_prev = ((k_m % TC) == TC - 1);
      k_m++;
      if (!busy_m) begin
        if (rise_m) begin
          busy_m = 1'b1;
          t_m    = 0;
        end
      end else begin
        if (tick_prev) t_m++;
        if (t_m == WALK_TICKS + HOLD) busy_m = 1'b0;
      end
      rise_m    = LAMP_TEST & ~lt_last_m;
      lt_last_m = LAMP_TEST;
      e.led = '0;
      for (int i = 0; i < 16; i++) begin
        if (busy_m)        nib = (t_m >= WALK_TICKS || (t_m / STEP) == i) ? LED_ON : LED_OFF;
        else if (FAULT[i]) nib = BLK_4HZ;
        else               nib = sh_m[i*4 +: 4];
        e.led[i*4 +: 4] = nib;
      end
      e.rdata = sh_m[host_bus.HOST_ADDR*8 +: 8];
      if (host_bus.HOST_WR) sh_m[host_bus.HOST_ADDR*8 +: 8] = host_bus.HOST_WDATA;
      e.busy = busy_m;
      e.clk  = model_clocks(k_m / TC);
      sb.push_back(e);
    end
  end

  // Monitor: every cycle out of reset the DUT presents a full output set.
  always @(negedge SYSCLK) begin : monitor_proc
    exp_t e;
    if (!RESET && sb.size() > 0) begin
      e = sb.pop_front();
      check_output("led_reg", {LED_REG7, LED_REG6, LED_REG5, LED_REG4,
                               LED_REG3, LED_REG2, LED_REG1, LED_REG0}, e.led);
      check_output("host_rdata", 64'(host_bus.HOST_RDATA), 64'(e.rdata));
      check_output("lamp_busy", 64'(LAMP_BUSY), 64'(e.busy));
      check_output("blink_clks", 64'({CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS,
                                      CLK_4HZ_3500MS, CLK_07S}), 64'(e.clk));
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                                input logic [15:0] fault, input logic lamp);
    @(negedge SYSCLK);
    host_bus.HOST_WR    = wr;
    host_bus.HOST_ADDR  = addr;
    host_bus.HOST_WDATA = wdata;
    FAULT               = fault;
    LAMP_TEST           = lamp;
  endtask

  task automatic check_reset_state();
    check_output("rst_led_reg", {LED_REG7, LED_REG6, LED_REG5, LED_REG4,
                                 LED_REG3, LED_REG2, LED_REG1, LED_REG0}, {8{SH_RESET}});
    check_output("rst_rdata", 64'(host_bus.HOST_RDATA), 64'h0);
    check_output("rst_busy", 64'(LAMP_BUSY), 64'h0);
    check_output("rst_clks", 64'({CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_500MS,
                                  CLK_4HZ_3500MS, CLK_07S}), 64'h0);
  endtask

  task automatic pulse_reset();
    @(posedge SYSCLK);
    #1;
    RESET = 1'b1;
    sb.delete();
    #1;
    check_reset_state();
    repeat (2) @(posedge SYSCLK);
    #2;
    RESET = 1'b0;
  endtask

  task automatic run_until_idle(input logic [15:0] fault, input int budget);
    int n = 0;
    while (LAMP_BUSY && n < budget) begin
      apply_stimulus(1'b0, 3'd5, 8'h00, fault, 1'b0);
      n++;
    end
    n_checks++;
    if (LAMP_BUSY) begin
      n_fail++;
      $display("[TB] FAIL lamp_timeout: busy=1 after %0d cycles, required 0", budget);
    end
  endtask

  initial begin
    logic [15:0] fault_cur;
    logic        lamp_cur;
    host_bus.HOST_WR    = 1'b0;
    host_bus.HOST_ADDR  = 3'd0;
    host_bus.HOST_WDATA = 8'h00;
    repeat (3) @(posedge SYSCLK);
    #1;
    check_reset_state();
    @(posedge SYSCLK);
    #2;
    RESET = 1'b0;

    $display("[TB] timebase free run");
    repeat (640) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b0);

    $display("[TB] host write and read-back");
    apply_stimulus(1'b1, 3'd3, {LED_ON, BLK_1HZ}, 16'h0, 1'b0);
    repeat (4) apply_stimulus(1'b0, 3'd3, 8'h00, 16'h0, 1'b0);
    apply_stimulus(1'b1, 3'd6, 8'hA7, 16'h0, 1'b0);
    repeat (3) apply_stimulus(1'b0, 3'd6, 8'h00, 16'h0, 1'b0);

    $display("[TB] fault override");
    apply_stimulus(1'b1, 3'd0, {LED_ON, LED_ON}, 16'h0, 1'b0);
    repeat (3) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b0);
    repeat (3) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0002, 1'b0);
    repeat (3) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b0);

    $display("[TB] lamp test with concurrent write and retrigger");
    repeat (2) apply_stimulus(1'b0, 3'd5, 8'h00, 16'hFFFF, 1'b1);
    repeat (100) apply_stimulus(1'b0, 3'd5, 8'h00, 16'hFFFF, 1'b0);
    apply_stimulus(1'b1, 3'd5, {BLK_2HZ, BLK_07S}, 16'hFFFF, 1'b0);
    repeat (50) apply_stimulus(1'b0, 3'd5, 8'h00, 16'hFFFF, 1'b0);
    repeat (3) apply_stimulus(1'b0, 3'd5, 8'h00, 16'hFFFF, 1'b1);
    run_until_idle(16'hFFFF, 900);
    repeat (5) apply_stimulus(1'b0, 3'd5, 8'h00, 16'h0, 1'b0);

    $display("[TB] reset during walk");
    repeat (2) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b1);
    repeat (60) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b0);
    pulse_reset();
    repeat (20) apply_stimulus(1'b0, 3'd0, 8'h00, 16'h0, 1'b0);

    $display("[TB] randomized traffic");
    fault_cur = '0;
    lamp_cur  = 1'b0;
    repeat (3000) begin
      if (($urandom % 32) == 0) fault_cur = 16'($urandom) & 16'($urandom);
      if (($urandom % 50) == 0) lamp_cur  = ~lamp_cur;
      apply_stimulus(($urandom % 4) == 0, 3'($urandom), 8'($urandom), fault_cur, lamp_cur);
    end
    repeat (3) apply_stimulus(1'b0, 3'd0, 8'h00, fault_cur, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
